// File: rtl/output_console_pkg.sv
// output_console_pkg: ASCII constants, formatter states and nibble-to-hex helper
package output_console_pkg;
  localparam logic [7:0] ASCII_NEWLINE = 8'h0A;
  localparam logic [7:0] ASCII_ZERO = 8'h30;
  localparam logic [7:0] ASCII_LOWER_A = 8'h61;
  typedef enum logic [1:0] {IDLE, LOAD, SEND} state_t;
  function automatic logic [7:0] hex_to_ascii(input logic [3:0] n);
    return (n < 4'd10) ? ASCII_ZERO + {4'd0, n} : ASCII_LOWER_A + {4'd0, n} - 8'd10;
  endfunction
endpackage

// File: rtl/uart_serializer.sv
// uart_serializer: 8N1 transmitter, one character per start strobe
module uart_serializer #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);
  logic          active;
  logic [CW-1:0] clk_cnt;
  logic [3:0]    bit_idx;
  logic [7:0]    shift;
  assign done = active && bit_idx == 4'd9 && clk_cnt == LAST;
  // bit_idx 0 is the start bit, 1..8 data, 9 stop; ones shifted in supply the stop level
  always_ff @(posedge clk) begin
    if (reset) begin
      active <= 1'b0;
      tx <= 1'b1;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift <= '0;
    end else if (!active) begin
      if (start) begin
        active <= 1'b1;
        tx <= 1'b0;
        shift <= data;
        clk_cnt <= '0;
        bit_idx <= '0;
      end
    end else if (clk_cnt != LAST) begin
      clk_cnt <= clk_cnt + 1'b1;
    end else begin
      clk_cnt <= '0;
      if (bit_idx == 4'd9) begin
        active <= 1'b0;
        tx <= 1'b1;
      end else begin
        bit_idx <= bit_idx + 1'b1;
        tx <= shift[0];
        shift <= {1'b1, shift[7:1]};
      end
    end
  end
endmodule

// File: rtl/output_console.sv
// output_console: buffers cluster output words and prints them as "%04x\n" over UART
module output_console
  import output_console_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [15:0]                   output_val,
  input  logic                          output_enable,
  output logic                          uart_tx,
  output logic                          busy,
  output logic                          overflow,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);
  logic [15:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [15:0]   hold;
  logic [2:0]    char_idx;
  state_t        state, state_nxt;
  logic          pop, push, start, done;
  logic [3:0]    nib;
  logic [7:0]    char_out;
  assign pop = state == IDLE && fifo_count != '0;
  assign push = output_enable && (fifo_count != FULL || pop);
  assign busy = fifo_count != '0 || state != IDLE;
  always_ff @(posedge clk) if (push) mem[wr_ptr] <= output_val;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      fifo_count <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      fifo_count <= fifo_count + (AW + 1)'(push) - (AW + 1)'(pop);
      overflow <= overflow | (output_enable & ~push);
    end
  end
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else state <= state_nxt;
  end
  always_comb begin
    state_nxt = state;
    state_nxt = state == IDLE ? (fifo_count != '0 ? LOAD : IDLE) :
                state == LOAD ? SEND :
                done ? (char_idx == 3'd4 ? IDLE : LOAD) : SEND;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      hold <= '0;
      char_idx <= '0;
    end else if (pop) begin
      hold <= mem[rd_ptr];
      char_idx <= '0;
    end else if (state == SEND && done && char_idx != 3'd4) begin
      char_idx <= char_idx + 1'b1;
    end
  end
  assign start = state == LOAD;
  assign nib = char_idx == 3'd0 ? hold[15:12] :
               char_idx == 3'd1 ? hold[11:8] :
               char_idx == 3'd2 ? hold[7:4] : hold[3:0];
  assign char_out = char_idx == 3'd4 ? ASCII_NEWLINE : hex_to_ascii(nib);
  uart_serializer #(.CLKS_PER_BIT(CLKS_PER_BIT)) u_ser (
    .clk(clk),
    .reset(reset),
    .start(start),
    .data(char_out),
    .tx(uart_tx),
    .done(done)
  );
endmodule

// File: tb/tb_output_console.sv
// tb_output_console: directed stimulus with a character scoreboard fed by a UART line decoder
module tb_output_console;
  localparam int CPB = 16;
  localparam int DEPTH = 8;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic output_enable = 1'b0;
  logic [15:0] output_val = '0;
  logic uart_tx, busy, overflow;
  logic [3:0] fifo_count;
  int cyc = 0;
  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];
  logic [7:0] rx_data[$];
  int rx_time[$];
  logic rx_ok[$];
  int rx_rd = 0;
  logic mon_on = 1'b0;
  int mon_cnt, mon_t;
  logic mon_ok;
  logic [7:0] mon_byte;

  output_console #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .output_val(output_val),
    .output_enable(output_enable),
    .uart_tx(uart_tx),
    .busy(busy),
    .overflow(overflow),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // line decoder: samples mid-bit on the falling edge, records byte, start cycle and framing
  always @(negedge clk) begin
    if (reset) mon_on = 1'b0;
    else if (!mon_on) begin
      if (uart_tx === 1'b0) begin
        mon_on = 1'b1;
        mon_cnt = 0;
        mon_t = cyc;
        mon_ok = 1'b1;
      end
    end else begin
      mon_cnt++;
      if (mon_cnt == CPB / 2 && uart_tx !== 1'b0) mon_ok = 1'b0;
      if (mon_cnt % CPB == CPB / 2 && mon_cnt > CPB && mon_cnt < 9 * CPB)
        mon_byte[3'(mon_cnt / CPB - 1)] = uart_tx;
      if (mon_cnt == 9 * CPB + CPB / 2) begin
        if (uart_tx !== 1'b1) mon_ok = 1'b0;
        rx_data.push_back(mon_byte);
        rx_time.push_back(mon_t);
        rx_ok.push_back(mon_ok);
        mon_on = 1'b0;
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_word(input logic [15:0] w);
    string s = $sformatf("%04x", w);
    for (int i = 0; i < 4; i++) exp_q.push_back(s[i]);
    exp_q.push_back(8'h0a);
  endtask

  task automatic strobe(input logic [15:0] w);
    output_val = w;
    output_enable = 1'b1;
    tick(1);
    output_enable = 1'b0;
  endtask

  task automatic wait_rx(input int n);
    int t = 0;
    while (rx_data.size() - rx_rd < n && t < n * 200 + 100) begin
      tick(1);
      t++;
    end
    check("rx_timeout", 32'(rx_data.size() - rx_rd >= n), 1);
  endtask

  task automatic wait_idle();
    int t = 0;
    while (busy && t < 20000) begin
      tick(1);
      t++;
    end
    check("idle_timeout", busy, 0);
  endtask

  task automatic compare_rx(input string tag, input int n);
    logic [7:0] e;
    wait_rx(n);
    for (int i = 0; i < n && rx_rd < rx_data.size(); i++) begin
      e = exp_q.size() != 0 ? exp_q.pop_front() : 8'hxx;
      check({tag, "_char"}, rx_data[rx_rd], e);
      check({tag, "_frame"}, rx_ok[rx_rd], 1);
      rx_rd++;
    end
    check({tag, "_sb_empty"}, exp_q.size(), 0);
  endtask

  initial begin
    int t0, t5;
    tick(3);
    check("rst_tx", uart_tx, 1);
    check("rst_busy", busy, 0);
    check("rst_ovf", overflow, 0);
    check("rst_cnt", fifo_count, 0);
    reset = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      tick(1);
      check("idle_tx", uart_tx, 1);
      check("idle_busy", busy, 0);
      check("idle_ovf", overflow, 0);
      check("idle_cnt", fifo_count, 0);
    end
    check("idle_no_rx", rx_data.size(), 0);

    // single word: latency, character spacing and busy release
    expect_word(16'h1a2f);
    strobe(16'h1a2f);
    t0 = cyc;
    wait_rx(5);
    check("first_start", rx_time[rx_rd] - t0, 2);
    for (int i = 1; i < 5; i++) check("spacing_1a2f", rx_time[rx_rd + i] - rx_time[rx_rd + i - 1], 10 * CPB + 1);
    t5 = rx_time[rx_rd + 4];
    compare_rx("w1a2f", 5);
    while (cyc < t5 + 10 * CPB - 1) tick(1);
    check("busy_last_stop", busy, 1);
    tick(1);
    check("busy_drop", busy, 0);
    check("tx_after", uart_tx, 1);

    // two words back to back
    wait_idle();
    expect_word(16'h0000);
    expect_word(16'hffff);
    strobe(16'h0000);
    strobe(16'hffff);
    wait_rx(10);
    for (int i = 1; i < 10; i++)
      if (i != 5) check("spacing_pair", rx_time[rx_rd + i] - rx_time[rx_rd + i - 1], 10 * CPB + 1);
    compare_rx("pair", 10);

    // burst of ten: nine fit (eight in FIFO plus holding register), tenth dropped
    wait_idle();
    for (int w = 1; w <= 10; w++) begin
      if (w <= 9) expect_word(16'(w));
      output_val = 16'(w);
      output_enable = 1'b1;
      tick(1);
      check("burst_ovf", overflow, 32'(w == 10));
      if (w >= 9) check("burst_cnt", fifo_count, DEPTH);
    end
    output_enable = 1'b0;
    compare_rx("burst", 45);
    wait_idle();
    check("ovf_sticky", overflow, 1);

    // reset in the middle of a data bit of the second character
    expect_word(16'hbeef);
    strobe(16'hbeef);
    t0 = cyc;
    wait_rx(1);
    check("beef_char0", rx_data[rx_rd], exp_q.pop_front());
    rx_rd++;
    exp_q.delete();
    while (cyc < t0 + 2 + 10 * CPB + 1 + 3 * CPB + CPB / 2) tick(1);
    check("pre_rst_busy", busy, 1);
    reset = 1'b1;
    tick(1);
    check("midrst_tx", uart_tx, 1);
    check("midrst_cnt", fifo_count, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ovf", overflow, 0);
    reset = 1'b0;
    tick(300);
    check("no_partial", rx_data.size() - rx_rd, 0);
    expect_word(16'h0042);
    strobe(16'h0042);
    compare_rx("w0042", 5);
    wait_idle();
    tick(200);
    check("no_extra", rx_data.size() - rx_rd, 0);

    // pointer wrap across four drained groups
    for (int g = 0; g < 4; g++) begin
      for (int i = 0; i < 5; i++) expect_word(16'h1000 + 16'(g * 5 + i) * 16'h0123);
      for (int i = 0; i < 5; i++) strobe(16'h1000 + 16'(g * 5 + i) * 16'h0123);
      compare_rx("wrap", 25);
      wait_idle();
      check("wrap_ovf", overflow, 0);
      check("wrap_cnt", fifo_count, 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
